player_motion_jump_ctrl: RTL and testbench
==========================================

Name: player_motion_jump_ctrl

Overview:
Per-frame player motion controller that sits directly upstream of the player sprite animation stages (stand/run/up/jump).
- Turns the decoded 4-bit keycode into PlayerX/PlayerY, playerDirection, moving and airborne status.
- Runs a ground/rise/fall jump state machine with integer gravity.
- Advances only on a once-per-frame strobe; all outputs hold between strobes.

Parameters:
X_START, 64, PlayerX after reset
GROUND_Y, 300, PlayerY (sprite top) when standing
X_MIN, 0, left clamp for PlayerX
X_MAX, 612, right clamp for PlayerX (640 - 28 sprite width)
X_STEP, 2, horizontal pixels per frame
JUMP_V, 10, initial upward speed, px/frame
GRAVITY, 1, speed added per frame while airborne
MAX_FALL, 12, downward speed clamp

Ports:
frame_Clk  in  1  clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  single-cycle pulse, once per video frame
keycode  in  4  0 none, 1 up, 2 left, 3 right, 4 jump, 5 jump+left, 6 jump+right, 7 down; others = none
PlayerX  out  10  sprite left edge
PlayerY  out  10  sprite top edge
playerDirection  out  1  0 facing right, 1 facing left
moving  out  1  horizontal key applied this frame while grounded
airborne  out  1  state != GROUND
keycode_q  out  4  keycode sampled on the last frame_tick; feeds the animation stages

Behaviour:
- Reset: PlayerX=X_START, PlayerY=GROUND_Y, playerDirection=0, moving=0, airborne=0, keycode_q=0, state=GROUND, vel=0, airDir=NONE.
- Reset mid-jump returns to these values on the next edge.
- Reset has priority over frame_tick.
- No frame_tick: every register holds.
- All updates occur on the frame_Clk edge where frame_tick=1. Outputs are registered, so there is one cycle of latency after the tick.
- vel is signed 6-bit. Y arithmetic is done in signed 11-bit, then truncated to 10 bits after clamping.
- GROUND state:
  - keycode 2 or 3: X -= / += X_STEP, clamped to [X_MIN, X_MAX]; playerDirection = 1 / 0; moving=1 even when clamped.
  - Any other key: moving=0.
  - Keycode 4/5/6: next state RISE; vel = -JUMP_V; PlayerY unchanged this tick.
    - airDir: NONE for 4, LEFT for 5, RIGHT for 6.
    - playerDirection is updated for 5/6.
    - For 5/6, X is not stepped on the takeoff tick.
- RISE state:
  - Y = Y + vel (clamped at 0), then vel = vel + GRAVITY.
  - If the new vel >= 0, next state is FALL.
- FALL state:
  - If Y + vel >= GROUND_Y: Y = GROUND_Y, vel = 0, next state GROUND (landing tick).
  - Otherwise Y = Y + vel and vel = min(vel + GRAVITY, MAX_FALL).
- RISE/FALL common:
  - X steps by X_STEP in airDir (clamped); no step when airDir is NONE.
  - keycode 2/3/5/6 is ignored for direction and X.
  - moving=0.
- Landing tick with a jump key held: the player lands only. A new jump requires a GROUND-state tick, so the earliest re-jump is the next frame.
- keycode_q <= keycode on every tick, in any state.

Decomposition:
- Package player_pkg holds:
  - keycode enum (KEY_NONE..KEY_DOWN)
  - state enum {GROUND, RISE, FALL}
  - airDir enum
  - screen constants (640x480, sprite 28x92)
  - default GROUND_Y
- The animation stages import the same package.
- One natural sub-module: player_vert_physics. It takes state, Y and vel, and produces nextY, nextVel and the land/apex flags. This isolates the signed arithmetic for unit test.
- The FSM and X logic stay in the top module.

Test Plan:
- Reset, then 3 idle ticks -> X=64, Y=300, dir=0, moving=0, airborne=0.
- keycode=3 for 10 ticks -> X=84, dir=0, moving=1. Then keycode=2 for 1 tick -> X=82, dir=1.
- Start X=610, keycode=3 for 3 ticks -> X=612 held, moving=1. Mirror test at X_MIN: X=1 -> 0.
- keycode=4 for 1 tick, then 0 (vertical jump):
  - Rise sequence: 290, 281, 273, 266, 260, 255, 251, 248, 246, 245 (enters FALL).
  - Fall sequence: 245, 246, 248, 251, 255, 260, 266, 273, 281, 290, 300 (lands).
  - airborne=1 for exactly 21 ticks; X unchanged.
- X=100, keycode=5 then keycode=3 held during flight -> dir stays 1, X decrements 2 per airborne tick to 58 at landing; X does not advance on the landing-frame-plus-one until the next tick.
- Jump held continuously -> lands at Y=300 on the landing tick, re-takes off on the next tick. Reset asserted at Y=260 mid-rise -> next edge X=64, Y=300, airborne=0.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and screen constants for the player motion and animation stages.
package player_pkg;

  // Decoded keyboard commands. Codes 8..15 are treated as no key.
  typedef enum logic [3:0] {
    KEY_NONE   = 4'd0,
    KEY_UP     = 4'd1,
    KEY_LEFT   = 4'd2,
    KEY_RIGHT  = 4'd3,
    KEY_JUMP   = 4'd4,
    KEY_JUMP_L = 4'd5,
    KEY_JUMP_R = 4'd6,
    KEY_DOWN   = 4'd7
  } key_e;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_e;

  // Horizontal drift latched at takeoff and held for the whole flight.
  typedef enum logic [1:0] {
    AIR_NONE  = 2'd0,
    AIR_LEFT  = 2'd1,
    AIR_RIGHT = 2'd2
  } air_dir_e;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPRITE_W     = 28;
  localparam int SPRITE_H     = 92;
  localparam int DEF_GROUND_Y = 300;

endpackage

// File: rtl/player_motion_jump_ctrl_vert_physics.sv
// Vertical motion step: applies velocity and gravity for one frame in the
// current jump state; reports the apex (rise done) and landing conditions.
module player_vert_physics
  import player_pkg::*;
#(
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  state_e             state,
  input  logic [9:0]         y,
  input  logic signed [5:0]  vel,
  output logic [9:0]         next_y,
  output logic signed [5:0]  next_vel,
  output logic               land,
  output logic               apex
);

  localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
  localparam logic signed [6:0]  MAX_FALL_S = 7'(MAX_FALL);

  logic signed [10:0] vel_ext;
  logic signed [10:0] y_sum;
  logic signed [6:0]  vel_inc;

  // Signed 11-bit Y sum so rising above row 0 can be detected and clamped.
  always_comb begin
    vel_ext  = {{5{vel[5]}}, vel};
    y_sum    = $signed({1'b0, y}) + vel_ext;
    vel_inc  = {vel[5], vel} + 7'(GRAVITY);
    next_y   = y;
    next_vel = vel;
    land     = 1'b0;
    apex     = 1'b0;
    case (state)
      RISE: begin
        next_y   = y_sum[10] ? 10'd0 : y_sum[9:0];
        next_vel = vel_inc[5:0];
        apex     = ~vel_inc[6];
      end
      FALL: begin
        if (y_sum >= GROUND_Y_S) begin
          next_y   = 10'(GROUND_Y);
          next_vel = 6'sd0;
          land     = 1'b1;
        end else begin
          next_y   = y_sum[9:0];
          next_vel = (vel_inc > MAX_FALL_S) ? MAX_FALL_S[5:0] : vel_inc[5:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/player_motion_jump_ctrl.sv
// Per-frame player motion: walking with edge clamps, ground/rise/fall jump FSM,
// facing direction and the keycode latch for the animation stages.
module player_motion_jump_ctrl
  import player_pkg::*;
#(
  parameter int X_START  = 64,
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = SCREEN_W - SPRITE_W,
  parameter int X_STEP   = 2,
  parameter int JUMP_V   = 10,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [3:0] keycode,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic       playerDirection,
  output logic       moving,
  output logic       airborne,
  output logic [3:0] keycode_q
);

  localparam logic signed [5:0] TAKEOFF_VEL = 6'(-JUMP_V);

  state_e            state_q, state_d;
  air_dir_e          air_dir_q, air_dir_d;
  logic signed [5:0] vel_q, vel_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dir_q, dir_d, moving_q, moving_d;
  logic [3:0]        keycode_d;

  logic [9:0]        x_left, x_right, phys_y;
  logic signed [5:0] phys_vel;
  logic              phys_land, phys_apex;

  // Clamped one-step X candidates, shared by walking and air drift.
  assign x_left  = (x_q < 10'(X_MIN + X_STEP)) ? 10'(X_MIN) : x_q - 10'(X_STEP);
  assign x_right = (x_q > 10'(X_MAX - X_STEP)) ? 10'(X_MAX) : x_q + 10'(X_STEP);

  player_vert_physics #(
    .GROUND_Y (GROUND_Y),
    .GRAVITY  (GRAVITY),
    .MAX_FALL (MAX_FALL)
  ) u_phys (
    .state    (state_q),
    .y        (y_q),
    .vel      (vel_q),
    .next_y   (phys_y),
    .next_vel (phys_vel),
    .land     (phys_land),
    .apex     (phys_apex)
  );

  // Next-state and datapath; everything holds unless frame_tick is high.
  always_comb begin
    state_d   = state_q;
    air_dir_d = air_dir_q;
    vel_d     = vel_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    moving_d  = moving_q;
    keycode_d = keycode_q;
    if (frame_tick) begin
      keycode_d = keycode;
      moving_d  = 1'b0;
      case (state_q)
        GROUND: begin
          case (keycode)
            KEY_LEFT:   begin x_d = x_left;  dir_d = 1'b1; moving_d = 1'b1; end
            KEY_RIGHT:  begin x_d = x_right; dir_d = 1'b0; moving_d = 1'b1; end
            KEY_JUMP:   begin state_d = RISE; vel_d = TAKEOFF_VEL; air_dir_d = AIR_NONE; end
            KEY_JUMP_L: begin state_d = RISE; vel_d = TAKEOFF_VEL; air_dir_d = AIR_LEFT;  dir_d = 1'b1; end
            KEY_JUMP_R: begin state_d = RISE; vel_d = TAKEOFF_VEL; air_dir_d = AIR_RIGHT; dir_d = 1'b0; end
            default: ;
          endcase
        end
        RISE, FALL: begin
          y_d   = phys_y;
          vel_d = phys_vel;
          if (air_dir_q == AIR_LEFT)  x_d = x_left;
          if (air_dir_q == AIR_RIGHT) x_d = x_right;
          if (state_q == RISE && phys_apex) state_d = FALL;
          // Landing tick only lands; a held jump key re-launches next frame.
          if (state_q == FALL && phys_land) begin
            state_d   = GROUND;
            air_dir_d = AIR_NONE;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over the tick.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      state_q   <= GROUND;
      air_dir_q <= AIR_NONE;
      vel_q     <= 6'sd0;
      x_q       <= 10'(X_START);
      y_q       <= 10'(GROUND_Y);
      dir_q     <= 1'b0;
      moving_q  <= 1'b0;
      keycode_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      air_dir_q <= air_dir_d;
      vel_q     <= vel_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      moving_q  <= moving_d;
      keycode_q <= keycode_d;
    end
  end

  assign PlayerX         = x_q;
  assign PlayerY         = y_q;
  assign playerDirection = dir_q;
  assign moving          = moving_q;
  assign airborne        = (state_q != GROUND);

endmodule

// File: tb/tb_player_motion_jump_ctrl.sv
// Directed bench for player_motion_jump_ctrl: walking, clamps, jump arcs,
// air drift, held jump and mid-air reset.
module tb_player_motion_jump_ctrl;

  logic       frame_Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] keycode = 4'd0;
  logic [9:0] PlayerX, PlayerY;
  logic       playerDirection, moving, airborne;
  logic [3:0] keycode_q;

  int checks = 0;
  int failures = 0;

  always #5 frame_Clk = ~frame_Clk;

  player_motion_jump_ctrl dut (
    .frame_Clk       (frame_Clk),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .keycode         (keycode),
    .PlayerX         (PlayerX),
    .PlayerY         (PlayerY),
    .playerDirection (playerDirection),
    .moving          (moving),
    .airborne        (airborne),
    .keycode_q       (keycode_q)
  );

  // One frame strobe with key k; outputs are sampled on the following negedge.
  task automatic tick(input logic [3:0] k);
    @(negedge frame_Clk);
    keycode = k;
    frame_tick = 1'b1;
    @(negedge frame_Clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge frame_Clk);
    Reset = 1'b1;
    frame_tick = 1'b0;
    keycode = 4'd0;
    @(negedge frame_Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) tick(4'd0);
    checks++; if (PlayerX !== 10'd64)   begin failures++; $display("FAIL reset_x got=%0d exp=64", PlayerX); end
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL reset_y got=%0d exp=300", PlayerY); end
    checks++; if (playerDirection !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", playerDirection); end
    checks++; if (moving !== 1'b0)      begin failures++; $display("FAIL reset_moving got=%0b exp=0", moving); end
    checks++; if (airborne !== 1'b0)    begin failures++; $display("FAIL reset_air got=%0b exp=0", airborne); end
    checks++; if (keycode_q !== 4'd0)   begin failures++; $display("FAIL reset_keyq got=%0d exp=0", keycode_q); end
    // Key held without a frame strobe must not move anything.
    @(negedge frame_Clk);
    keycode = 4'd3;
    repeat (5) @(negedge frame_Clk);
    checks++; if (PlayerX !== 10'd64)   begin failures++; $display("FAIL hold_no_tick_x got=%0d exp=64", PlayerX); end
    checks++; if (keycode_q !== 4'd0)   begin failures++; $display("FAIL hold_no_tick_keyq got=%0d exp=0", keycode_q); end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 10; i++) tick(4'd3);
    checks++; if (PlayerX !== 10'd84)   begin failures++; $display("FAIL walk_right_x got=%0d exp=84", PlayerX); end
    checks++; if (playerDirection !== 1'b0) begin failures++; $display("FAIL walk_right_dir got=%0b exp=0", playerDirection); end
    checks++; if (moving !== 1'b1)      begin failures++; $display("FAIL walk_right_moving got=%0b exp=1", moving); end
    checks++; if (keycode_q !== 4'd3)   begin failures++; $display("FAIL walk_keyq got=%0d exp=3", keycode_q); end
    tick(4'd2);
    checks++; if (PlayerX !== 10'd82)   begin failures++; $display("FAIL walk_left_x got=%0d exp=82", PlayerX); end
    checks++; if (playerDirection !== 1'b1) begin failures++; $display("FAIL walk_left_dir got=%0b exp=1", playerDirection); end
    tick(4'd9);
    checks++; if (moving !== 1'b0)      begin failures++; $display("FAIL bad_key_moving got=%0b exp=0", moving); end
    checks++; if (PlayerX !== 10'd82)   begin failures++; $display("FAIL bad_key_x got=%0d exp=82", PlayerX); end
    checks++; if (keycode_q !== 4'd9)   begin failures++; $display("FAIL bad_key_keyq got=%0d exp=9", keycode_q); end
  endtask

  task automatic test_clamp();
    // From 82, 264 right steps reach 610.
    for (int i = 0; i < 264; i++) tick(4'd3);
    checks++; if (PlayerX !== 10'd610)  begin failures++; $display("FAIL walk_to_610 got=%0d exp=610", PlayerX); end
    for (int i = 0; i < 3; i++) begin
      tick(4'd3);
      checks++; if (PlayerX !== 10'd612) begin failures++; $display("FAIL clamp_max_x step=%0d got=%0d exp=612", i, PlayerX); end
      checks++; if (moving !== 1'b1)     begin failures++; $display("FAIL clamp_max_moving step=%0d got=%0b exp=1", i, moving); end
    end
    // From 612, 305 left steps reach 2.
    for (int i = 0; i < 305; i++) tick(4'd2);
    checks++; if (PlayerX !== 10'd2)    begin failures++; $display("FAIL walk_to_2 got=%0d exp=2", PlayerX); end
    for (int i = 0; i < 3; i++) begin
      tick(4'd2);
      checks++; if (PlayerX !== 10'd0)  begin failures++; $display("FAIL clamp_min_x step=%0d got=%0d exp=0", i, PlayerX); end
      checks++; if (moving !== 1'b1)    begin failures++; $display("FAIL clamp_min_moving step=%0d got=%0b exp=1", i, moving); end
    end
  endtask

  task automatic test_vertical_jump();
    int exp_y [21] = '{290, 281, 273, 266, 260, 255, 251, 248, 246, 245,
                       245, 246, 248, 251, 255, 260, 266, 273, 281, 290, 300};
    int air_cnt;
    do_reset();
    tick(4'd4);
    air_cnt = airborne ? 1 : 0;
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL takeoff_y got=%0d exp=300", PlayerY); end
    checks++; if (airborne !== 1'b1)    begin failures++; $display("FAIL takeoff_air got=%0b exp=1", airborne); end
    for (int i = 0; i < 21; i++) begin
      tick(4'd0);
      if (airborne) air_cnt++;
      checks++; if (PlayerY !== 10'(exp_y[i])) begin failures++; $display("FAIL jump_y tick=%0d got=%0d exp=%0d", i, PlayerY, exp_y[i]); end
      checks++; if (moving !== 1'b0)    begin failures++; $display("FAIL jump_moving tick=%0d got=%0b exp=0", i, moving); end
    end
    checks++; if (air_cnt != 21)        begin failures++; $display("FAIL jump_air_ticks got=%0d exp=21", air_cnt); end
    checks++; if (airborne !== 1'b0)    begin failures++; $display("FAIL jump_landed_air got=%0b exp=0", airborne); end
    checks++; if (PlayerX !== 10'd64)   begin failures++; $display("FAIL jump_x got=%0d exp=64", PlayerX); end
  endtask

  task automatic test_jump_left();
    do_reset();
    for (int i = 0; i < 18; i++) tick(4'd3);
    checks++; if (PlayerX !== 10'd100)  begin failures++; $display("FAIL pre_jump_x got=%0d exp=100", PlayerX); end
    tick(4'd5);
    checks++; if (PlayerX !== 10'd100)  begin failures++; $display("FAIL takeoff_left_x got=%0d exp=100", PlayerX); end
    checks++; if (playerDirection !== 1'b1) begin failures++; $display("FAIL takeoff_left_dir got=%0b exp=1", playerDirection); end
    for (int i = 0; i < 21; i++) begin
      tick(4'd3);
      checks++; if (PlayerX !== 10'(100 - 2 * (i + 1))) begin failures++; $display("FAIL drift_x tick=%0d got=%0d exp=%0d", i, PlayerX, 100 - 2 * (i + 1)); end
      checks++; if (playerDirection !== 1'b1) begin failures++; $display("FAIL drift_dir tick=%0d got=%0b exp=1", i, playerDirection); end
      checks++; if (airborne !== (i < 20)) begin failures++; $display("FAIL drift_air tick=%0d got=%0b exp=%0b", i, airborne, i < 20); end
    end
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL drift_land_y got=%0d exp=300", PlayerY); end
    tick(4'd3);
    checks++; if (PlayerX !== 10'd60)   begin failures++; $display("FAIL after_land_x got=%0d exp=60", PlayerX); end
    checks++; if (playerDirection !== 1'b0) begin failures++; $display("FAIL after_land_dir got=%0b exp=0", playerDirection); end
    checks++; if (moving !== 1'b1)      begin failures++; $display("FAIL after_land_moving got=%0b exp=1", moving); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 22; i++) tick(4'd4);
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL held_land_y got=%0d exp=300", PlayerY); end
    checks++; if (airborne !== 1'b0)    begin failures++; $display("FAIL held_land_air got=%0b exp=0", airborne); end
    tick(4'd4);
    checks++; if (airborne !== 1'b1)    begin failures++; $display("FAIL rejump_air got=%0b exp=1", airborne); end
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL rejump_y got=%0d exp=300", PlayerY); end
    for (int i = 0; i < 5; i++) tick(4'd0);
    checks++; if (PlayerY !== 10'd260)  begin failures++; $display("FAIL mid_rise_y got=%0d exp=260", PlayerY); end
    // Reset asserted together with a strobe: reset wins.
    @(negedge frame_Clk);
    Reset = 1'b1;
    frame_tick = 1'b1;
    keycode = 4'd3;
    @(negedge frame_Clk);
    Reset = 1'b0;
    frame_tick = 1'b0;
    checks++; if (PlayerX !== 10'd64)   begin failures++; $display("FAIL midair_reset_x got=%0d exp=64", PlayerX); end
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL midair_reset_y got=%0d exp=300", PlayerY); end
    checks++; if (airborne !== 1'b0)    begin failures++; $display("FAIL midair_reset_air got=%0b exp=0", airborne); end
    checks++; if (keycode_q !== 4'd0)   begin failures++; $display("FAIL midair_reset_keyq got=%0d exp=0", keycode_q); end
    tick(4'd0);
    checks++; if (PlayerY !== 10'd300)  begin failures++; $display("FAIL post_reset_y got=%0d exp=300", PlayerY); end
    checks++; if (airborne !== 1'b0)    begin failures++; $display("FAIL post_reset_air got=%0b exp=0", airborne); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_clamp();
    test_vertical_jump();
    test_jump_left();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
